coh_noc_vc_link_arbiter: RTL and testbench

Shares one physical NoC link between the four CHI virtual channels (REQ, RSP, DAT, SNP) using per-VC credit-based flow control and round-robin arbitration. It sits at every router output port and network-interface egress. Each cycle it grants at most one VC whose source has a flit and whose downstream buffer has credit. It registers the granted flit onto the link and tracks credits returned by the receiver.

---
 rtl/coh_noc_vc_link_arbiter.sv | 76 +++++++
 tb/tb_coh_noc_vc_link_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/coh_noc_vc_link_arbiter.sv
// coh_noc_vc_link_arbiter: round-robin, credit-flow-controlled sharing of one NoC link among CHI virtual channels
module coh_noc_vc_link_arbiter #(
  parameter int NUM_VC       = 4,
  parameter int FLIT_W       = 731,
  parameter int CREDIT_W     = 8,
  parameter int INIT_CREDITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_VC-1:0]          in_valid,
  input  logic [NUM_VC*FLIT_W-1:0]   in_flit,
  output logic [NUM_VC-1:0]          in_ready,
  output logic                       out_valid,
  output logic [1:0]                 out_vc,
  output logic [FLIT_W-1:0]          out_flit,
  input  logic [NUM_VC-1:0]          credit_return,
  output logic [NUM_VC*CREDIT_W-1:0] credits,
  output logic                       cred_err
);
  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(INIT_CREDITS);
  logic [CREDIT_W-1:0] cnt [NUM_VC];
  logic [1:0] rr_ptr, gidx, idx;
  logic found;
  logic [NUM_VC-1:0] elig, grant, full_ret;
  // Eligibility and round-robin search starting at rr_ptr; grant is forced off while in reset
  always_comb begin
    elig = '0;
    grant = '0;
    full_ret = '0;
    gidx = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_VC; k++) elig[k] = !rst && in_valid[k] && (cnt[k] != '0);
    for (int k = 0; k < NUM_VC; k++) begin
      idx = 2'((int'(rr_ptr) + k) % NUM_VC);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        gidx = idx;
        found = 1'b1;
      end
    end
    for (int k = 0; k < NUM_VC; k++) full_ret[k] = credit_return[k] && !grant[k] && (cnt[k] == FULL);
  end
  assign in_ready = grant;
  // Link output register and round-robin pointer advance past the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vc <= '0;
      out_flit <= '0;
      rr_ptr <= '0;
    end else begin
      out_valid <= found;
      if (found) begin
        out_vc <= gidx;
        out_flit <= in_flit[gidx*FLIT_W +: FLIT_W];
        rr_ptr <= 2'((int'(gidx) + 1) % NUM_VC);
      end
    end
  end
  // Per-VC credit counters: send consumes, return restores, saturating at the buffer depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int k = 0; k < NUM_VC; k++) cnt[k] <= FULL;
    else for (int k = 0; k < NUM_VC; k++)
      cnt[k] <= (grant[k] && !credit_return[k]) ? cnt[k] - 1'b1 :
                (!grant[k] && credit_return[k] && cnt[k] != FULL) ? cnt[k] + 1'b1 : cnt[k];
  end
  // Sticky flag for a credit returned into an already-full counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cred_err <= 1'b0;
    else if (|full_ret) cred_err <= 1'b1;
  end
  for (genvar i = 0; i < NUM_VC; i++) begin : g_cred
    assign credits[i*CREDIT_W +: CREDIT_W] = cnt[i];
  end
endmodule

// File: tb/tb_coh_noc_vc_link_arbiter.sv
// tb_coh_noc_vc_link_arbiter: directed and random checks of the VC link arbiter against a behavioural model
module tb_coh_noc_vc_link_arbiter;
  localparam int NV = 4;
  localparam int FW = 731;
  localparam int CW = 8;
  localparam int INIT = 16;
  logic clk, rst;
  logic [NV-1:0] in_valid, in_ready, credit_return;
  logic [NV*FW-1:0] in_flit;
  logic out_valid, cred_err;
  logic [1:0] out_vc;
  logic [FW-1:0] out_flit;
  logic [NV*CW-1:0] credits;
  int total, bad;
  int cnt_m [NV];
  int ptr_m, ovc_m, nsent;
  bit err_m, ov_m;
  logic [FW-1:0] of_m;

  coh_noc_vc_link_arbiter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit),
    .credit_return(credit_return), .credits(credits), .cred_err(cred_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [1023:0] obs, logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rflit();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < FW; i += 32) f = (f << 32) | FW'($urandom);
    return f;
  endfunction

  function automatic logic [NV*CW-1:0] exp_credits();
    logic [NV*CW-1:0] c;
    for (int v = 0; v < NV; v++) c[v*CW +: CW] = CW'(cnt_m[v]);
    return c;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) cnt_m[v] = INIT;
    ptr_m = 0;
    err_m = 0;
    ov_m = 0;
    ovc_m = 0;
    of_m = '0;
  endtask

  task automatic tick();
    int g;
    logic [NV-1:0] er;
    #1;
    g = -1;
    er = '0;
    for (int k = 0; k < NV; k++) begin
      int v;
      v = (ptr_m + k) % NV;
      if (g < 0 && in_valid[v] && cnt_m[v] > 0) g = v;
    end
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    if (g >= 0) begin
      ov_m = 1;
      ovc_m = g;
      of_m = in_flit[g*FW +: FW];
      ptr_m = (g + 1) % NV;
    end else ov_m = 0;
    for (int v = 0; v < NV; v++) begin
      if (v == g && credit_return[v]) ;
      else if (v == g) cnt_m[v]--;
      else if (credit_return[v]) begin
        if (cnt_m[v] == INIT) err_m = 1;
        else cnt_m[v]++;
      end
    end
    @(negedge clk);
    chk("out_valid", out_valid, ov_m);
    chk("out_vc", out_vc, ovc_m);
    chk("out_flit", out_flit, of_m);
    chk("credits", credits, exp_credits());
    chk("cred_err", cred_err, err_m);
  endtask

  task automatic areset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_vc", out_vc, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_credits", credits, exp_credits());
    chk("rst_cred_err", cred_err, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 4'hF;
    credit_return = '0;
    in_flit = '0;
    model_reset();
    @(negedge clk);
    chk("init_out_valid", out_valid, 0);
    chk("init_in_ready", in_ready, 0);
    chk("init_credits", credits, exp_credits());
    chk("init_cred_err", cred_err, 0);
    rst = 1'b0;
    in_valid = 4'b0100;
    nsent = 0;
    for (int i = 0; i < 20; i++) begin
      for (int v = 0; v < NV; v++) in_flit[v*FW +: FW] = rflit();
      tick();
      if (out_valid && out_vc == 2'd2) nsent++;
    end
    chk("dat_sent", nsent, 16);
    chk("dat_credits", credits[2*CW +: CW], 0);
    areset();
    in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      for (int v = 0; v < NV; v++) in_flit[v*FW +: FW] = rflit();
      tick();
      chk("rr_valid", out_valid, 1);
      chk("rr_order", out_vc, i % 4);
    end
    areset();
    in_valid = 4'b0010;
    repeat (16) tick();
    chk("rsp_drained", credits[1*CW +: CW], 0);
    in_valid = 4'b0001;
    tick();
    in_valid = 4'hF;
    tick();
    chk("skip_vc", out_vc, 2);
    in_valid = 4'b0010;
    credit_return = 4'b0010;
    tick();
    chk("ret_no_bypass", out_valid, 0);
    chk("ret_credit", credits[1*CW +: CW], 1);
    credit_return = '0;
    tick();
    chk("ret_grant_vc", out_vc, 1);
    chk("ret_credit_used", credits[1*CW +: CW], 0);
    areset();
    in_valid = 4'b0001;
    repeat (11) tick();
    chk("req_at5", credits[0 +: CW], 5);
    credit_return = 4'b0001;
    tick();
    chk("sim_credit", credits[0 +: CW], 5);
    chk("sim_others", credits[NV*CW-1:CW], {CW'(INIT), CW'(INIT), CW'(INIT)});
    credit_return = 4'b1000;
    in_valid = '0;
    tick();
    credit_return = '0;
    chk("ovf_credit", credits[3*CW +: CW], 16);
    chk("ovf_err", cred_err, 1);
    repeat (3) tick();
    chk("ovf_sticky", cred_err, 1);
    areset();
    for (int i = 0; i < 400; i++) begin
      in_valid = NV'($urandom);
      for (int v = 0; v < NV; v++) begin
        credit_return[v] = (cnt_m[v] < INIT) && ($urandom_range(2) == 0);
        in_flit[v*FW +: FW] = rflit();
      end
      tick();
      if (i == 200) begin
        credit_return = '0;
        areset();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
